// File: rtl/mlp_seq_pkg.sv
// Shared types and index helpers for the sequential MLP engine.
// Keeps the flat weight/bias packing of the combinational generation.
package mlp_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    L0,
    L1,
    DONE
  } state_e;

  function automatic int prod_w(input int opa_w, input int ww);
    return opa_w + ww + 1;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int w0_idx(input int h, input int a,
                                input int num_a);
    return h * num_a + a;
  endfunction

  function automatic int w1_idx(input int o, input int h,
                                input int num_a, input int num_h);
    return num_a * num_h + o * num_h + h;
  endfunction

  function automatic int b0_lo(input int h, input int wb0);
    return h * wb0;
  endfunction

  function automatic int b1_lo(input int o, input int num_h,
                               input int wb0, input int wb1);
    return num_h * wb0 + o * wb1;
  endfunction

endpackage

// File: rtl/mlp_seq_engine_mac.sv
// Shared signed multiply-accumulate used by both layers.
// Combinational: next accumulator value, or bias when loading.
module mlp_mac
  import mlp_seq_pkg::*;
#(
  parameter int OPA_W = 17,
  parameter int OPB_W = 8,
  parameter int ACC_W = 28
) (
  input  logic                    load,
  input  logic signed [ACC_W-1:0] bias,
  input  logic signed [ACC_W-1:0] acc_in,
  input  logic signed [OPA_W-1:0] op_a,
  input  logic signed [OPB_W-1:0] op_b,
  output logic signed [ACC_W-1:0] acc_out
);

  localparam int PW = prod_w(OPA_W - 1, OPB_W);

  logic signed [PW-1:0] prod;

  // product sign-extended into the accumulator; wraps on overflow
  always_comb begin
    prod    = op_a * op_b;
    acc_out = load ? bias : acc_in + ACC_W'(prod);
  end

endmodule

// File: rtl/mlp_seq_engine.sv
// Time-multiplexed two-layer MLP classifier with argmax output.
// One shared MAC, one multiply per cycle, valid/ready on both sides.
module mlp_seq_engine
  import mlp_seq_pkg::*;
#(
  parameter int NUM_A    = 4,
  parameter int WIDTH_A  = 4,
  parameter int NUM_H    = 3,
  parameter int NUM_O    = 3,
  parameter int WIDTH_W  = 8,
  parameter int WIDTH_B0 = 11,
  parameter int WIDTH_B1 = 17,
  parameter int ACC0_W   = 16,
  parameter int ACC1_W   = 28,
  parameter int OUTWIDTH = $clog2(NUM_O)
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [NUM_A*WIDTH_A-1:0]                     inp,
  input  logic [(NUM_A*NUM_H+NUM_H*NUM_O)*WIDTH_W-1:0] weights,
  input  logic [NUM_H*WIDTH_B0+NUM_O*WIDTH_B1-1:0]     biases,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  output logic [OUTWIDTH-1:0]                          out,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic                                         busy
);

  localparam int AW    = cnt_w(NUM_A);
  localparam int HW    = cnt_w(NUM_H);
  localparam int OPA_W = ACC0_W + 1;

  localparam logic [AW-1:0]       A_LAST = AW'(NUM_A - 1);
  localparam logic [HW-1:0]       H_LAST = HW'(NUM_H - 1);
  localparam logic [OUTWIDTH-1:0] O_LAST = OUTWIDTH'(NUM_O - 1);

  state_e state_q, state_d;

  logic [NUM_A*WIDTH_A-1:0] x_q, x_d;
  logic [AW-1:0]            a_q, a_d;
  logic [HW-1:0]            h_q, h_d;
  logic [OUTWIDTH-1:0]      o_q, o_d;
  logic [OUTWIDTH-1:0]      bidx_q, bidx_d;
  logic [OUTWIDTH-1:0]      out_q, out_d;
  logic                     ov_q, ov_d;

  logic signed [ACC0_W-1:0] acc0_q, acc0_d;
  logic signed [ACC1_W-1:0] acc1_q, acc1_d;
  logic signed [ACC1_W-1:0] best_q, best_d;

  logic [ACC0_W-1:0] hid_q [NUM_H];
  logic [ACC0_W-1:0] hid_d [NUM_H];

  logic [WIDTH_A-1:0]        x_sel;
  logic [WIDTH_W-1:0]        w0_sel;
  logic [WIDTH_W-1:0]        w1_sel;
  logic [HW-1:0]             h_nxt;
  logic [OUTWIDTH-1:0]       o_nxt;
  logic signed [WIDTH_B0-1:0] b0_first;
  logic signed [WIDTH_B0-1:0] b0_nxt;
  logic signed [WIDTH_B1-1:0] b1_first;
  logic signed [WIDTH_B1-1:0] b1_nxt;

  logic                     mac_load;
  logic signed [ACC1_W-1:0] mac_bias;
  logic signed [ACC1_W-1:0] mac_in;
  logic signed [OPA_W-1:0]  op_a;
  logic signed [WIDTH_W-1:0] op_b;
  logic signed [ACC1_W-1:0] mac_out;
  logic signed [ACC0_W-1:0] sum0;
  logic                     upd;

  // operand and bias selection feeding the shared MAC
  always_comb begin
    x_sel  = x_q[int'(a_q)*WIDTH_A +: WIDTH_A];
    w0_sel = weights[w0_idx(int'(h_q), int'(a_q), NUM_A)*WIDTH_W +: WIDTH_W];
    w1_sel = weights[w1_idx(int'(o_q), int'(h_q), NUM_A, NUM_H)*WIDTH_W
                     +: WIDTH_W];
    h_nxt  = (h_q == H_LAST) ? '0 : h_q + 1'b1;
    o_nxt  = (o_q == O_LAST) ? '0 : o_q + 1'b1;
    b0_first = biases[b0_lo(0, WIDTH_B0) +: WIDTH_B0];
    b0_nxt   = biases[b0_lo(int'(h_nxt), WIDTH_B0) +: WIDTH_B0];
    b1_first = biases[b1_lo(0, NUM_H, WIDTH_B0, WIDTH_B1) +: WIDTH_B1];
    b1_nxt   = biases[b1_lo(int'(o_nxt), NUM_H, WIDTH_B0, WIDTH_B1)
                      +: WIDTH_B1];
    mac_load = (state_q == IDLE);
    mac_bias = ACC1_W'(b0_first);
    if (state_q == L1) begin
      mac_in = acc1_q;
      op_a   = {1'b0, hid_q[h_q]};
      op_b   = w1_sel;
    end else begin
      mac_in = ACC1_W'(acc0_q);
      op_a   = OPA_W'(x_sel);
      op_b   = w0_sel;
    end
  end

  mlp_mac #(
    .OPA_W (OPA_W),
    .OPB_W (WIDTH_W),
    .ACC_W (ACC1_W)
  ) u_mac (
    .load    (mac_load),
    .bias    (mac_bias),
    .acc_in  (mac_in),
    .op_a    (op_a),
    .op_b    (op_b),
    .acc_out (mac_out)
  );

  // sequencing: accept, layer 0, layer 1 with running argmax, hold result
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    a_d     = a_q;
    h_d     = h_q;
    o_d     = o_q;
    bidx_d  = bidx_q;
    out_d   = out_q;
    ov_d    = ov_q;
    acc0_d  = acc0_q;
    acc1_d  = acc1_q;
    best_d  = best_q;
    hid_d   = hid_q;
    sum0    = mac_out[ACC0_W-1:0];
    upd     = (o_q == '0) || (mac_out > best_q);
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = inp;
          acc0_d  = sum0;
          a_d     = '0;
          h_d     = '0;
          state_d = L0;
        end
      end
      L0: begin
        if (a_q == A_LAST) begin
          a_d        = '0;
          hid_d[h_q] = sum0[ACC0_W-1] ? '0 : sum0;
          acc0_d     = ACC0_W'(b0_nxt);
          h_d        = h_nxt;
          if (h_q == H_LAST) begin
            o_d     = '0;
            acc1_d  = ACC1_W'(b1_first);
            state_d = L1;
          end
        end else begin
          acc0_d = sum0;
          a_d    = a_q + 1'b1;
        end
      end
      L1: begin
        if (h_q == H_LAST) begin
          h_d    = '0;
          acc1_d = ACC1_W'(b1_nxt);
          o_d    = o_nxt;
          if (upd) begin
            best_d = mac_out;
            bidx_d = o_q;
          end
          if (o_q == O_LAST) begin
            out_d   = upd ? o_q : bidx_q;
            ov_d    = 1'b1;
            state_d = DONE;
          end
        end else begin
          acc1_d = mac_out;
          h_d    = h_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      a_q     <= '0;
      h_q     <= '0;
      o_q     <= '0;
      bidx_q  <= '0;
      out_q   <= '0;
      ov_q    <= 1'b0;
      acc0_q  <= '0;
      acc1_q  <= '0;
      best_q  <= '0;
      for (int i = 0; i < NUM_H; i++) hid_q[i] <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      a_q     <= a_d;
      h_q     <= h_d;
      o_q     <= o_d;
      bidx_q  <= bidx_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
      acc0_q  <= acc0_d;
      acc1_q  <= acc1_d;
      best_q  <= best_d;
      for (int i = 0; i < NUM_H; i++) hid_q[i] <= hid_d[i];
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == L0) || (state_q == L1);
  assign out       = out_q;
  assign out_valid = ov_q;

endmodule

// File: tb/tb_mlp_seq_engine.sv
// Directed bench for mlp_seq_engine with an expected-class scoreboard.
// Reference classes come from constants or a small bench-side model.
module tb_mlp_seq_engine;

  localparam int NA  = 4;
  localparam int WA  = 4;
  localparam int NH  = 3;
  localparam int NO  = 3;
  localparam int WW  = 8;
  localparam int WB0 = 11;
  localparam int WB1 = 17;
  localparam int LAT = NA * NH + NH * NO;

  logic                            clk;
  logic                            rst;
  logic [NA*WA-1:0]                inp;
  logic [(NA*NH+NH*NO)*WW-1:0]     weights;
  logic [NH*WB0+NO*WB1-1:0]        biases;
  logic                            in_valid;
  logic                            in_ready;
  logic [1:0]                      out;
  logic                            out_valid;
  logic                            out_ready;
  logic                            busy;

  int w0 [NH][NA];
  int w1 [NO][NH];
  int b0 [NH];
  int b1 [NO];

  int pass_cnt;
  int fail_cnt;
  int total_cnt;
  int exp_q [$];

  mlp_seq_engine dut (
    .clk       (clk),
    .rst       (rst),
    .inp       (inp),
    .weights   (weights),
    .biases    (biases),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic apply_coeffs();
    for (int h = 0; h < NH; h++)
      for (int a = 0; a < NA; a++)
        weights[(h*NA+a)*WW +: WW] = WW'(w0[h][a]);
    for (int o = 0; o < NO; o++)
      for (int h = 0; h < NH; h++)
        weights[(NA*NH+o*NH+h)*WW +: WW] = WW'(w1[o][h]);
    for (int h = 0; h < NH; h++)
      biases[h*WB0 +: WB0] = WB0'(b0[h]);
    for (int o = 0; o < NO; o++)
      biases[NH*WB0+o*WB1 +: WB1] = WB1'(b1[o]);
  endtask

  task automatic zero_coeffs();
    for (int h = 0; h < NH; h++) begin
      b0[h] = 0;
      for (int a = 0; a < NA; a++) w0[h][a] = 0;
    end
    for (int o = 0; o < NO; o++) begin
      b1[o] = 0;
      for (int h = 0; h < NH; h++) w1[o][h] = 0;
    end
  endtask

  function automatic int model(input logic [NA*WA-1:0] x);
    logic signed [15:0] a0;
    logic signed [27:0] a1;
    logic signed [27:0] best;
    logic [15:0]        hid [NH];
    int                 bi;
    best = '0;
    bi   = 0;
    for (int h = 0; h < NH; h++) begin
      a0 = 16'(b0[h]);
      for (int a = 0; a < NA; a++)
        a0 = a0 + 16'(int'(x[a*WA +: WA]) * w0[h][a]);
      hid[h] = a0[15] ? 16'd0 : a0;
    end
    for (int o = 0; o < NO; o++) begin
      a1 = 28'(b1[o]);
      for (int h = 0; h < NH; h++)
        a1 = a1 + 28'(int'(hid[h]) * w1[o][h]);
      if (o == 0 || a1 > best) begin
        best = a1;
        bi   = o;
      end
    end
    return bi;
  endfunction

  task automatic send(input logic [NA*WA-1:0] x, input int exp);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    inp      = x;
    in_valid = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic get_result(input int hold, input bit pulse);
    int lat;
    int bcnt;
    int exp;
    bcnt = busy ? 1 : 0;
    lat  = 0;
    while (lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
      if (busy) bcnt++;
    end
    chk("latency", 32'(lat), 32'(LAT));
    chk("busy_cycles", 32'(bcnt), 32'(LAT));
    chk("busy_done", 32'(busy), 32'd0);
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    else exp = -1;
    chk("class", 32'(out), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      in_valid = pulse && i >= 2 && i < 6;
      if (pulse) inp = ~inp;
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_out", 32'(out), 32'(exp));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("post_out", 32'(out), 32'(exp));
    if (pulse) begin
      @(posedge clk);
      #1;
      chk("no_accept_busy", 32'(busy), 32'd0);
      chk("no_accept_ready", 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    logic [NA*WA-1:0] v;
    pass_cnt  = 0;
    fail_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    inp       = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    weights   = '0;
    biases    = '0;
    zero_coeffs();
    apply_coeffs();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);

    b1[0] = 5;
    b1[1] = 9;
    b1[2] = -3;
    apply_coeffs();
    send(16'h9a3c, 1);
    get_result(0, 1'b0);

    b1[0] = 7;
    b1[1] = 7;
    b1[2] = 7;
    apply_coeffs();
    send(16'h1234, 0);
    get_result(0, 1'b0);

    zero_coeffs();
    for (int h = 0; h < NH; h++)
      for (int a = 0; a < NA; a++) w0[h][a] = 1;
    b0[0] = 0;
    b0[1] = -100;
    b0[2] = -100;
    w1[2][0] = 2;
    apply_coeffs();
    send(16'hffff, 2);
    get_result(0, 1'b0);

    b0[0] = -100;
    b1[0] = -1;
    b1[1] = 4;
    b1[2] = 2;
    apply_coeffs();
    send(16'hffff, 1);
    get_result(10, 1'b1);

    for (int h = 0; h < NH; h++) begin
      b0[h] = int'($urandom_range(0, 2047)) - 1024;
      for (int a = 0; a < NA; a++)
        w0[h][a] = int'($urandom_range(0, 255)) - 128;
    end
    for (int o = 0; o < NO; o++) begin
      b1[o] = int'($urandom_range(0, 131071)) - 65536;
      for (int h = 0; h < NH; h++)
        w1[o][h] = int'($urandom_range(0, 255)) - 128;
    end
    apply_coeffs();
    v = 16'h5a7e;
    send(v, model(v));
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);

    v = 16'hc3f1;
    send(v, model(v));
    get_result(0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      for (int o = 0; o < NO; o++)
        for (int h = 0; h < NH; h++)
          w1[o][h] = int'($urandom_range(0, 255)) - 128;
      for (int h = 0; h < NH; h++)
        for (int a = 0; a < NA; a++)
          w0[h][a] = int'($urandom_range(0, 255)) - 128;
      apply_coeffs();
      v = 16'($urandom);
      send(v, model(v));
      get_result(k % 3, 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mlp_seq_engine.md
Name: mlp_seq_engine

Overview:
- Sequential, time-multiplexed successor to the fully combinational two-layer printed MLP classifier.
- Evaluates an N-input / H-hidden (ReLU) / O-output network with a single shared signed MAC, one multiply per cycle, and ends with an argmax class index.
- Sits between the sensor input register and the classification consumer, using valid/ready handshakes on both sides.
- Weight and bias buses keep the same flat packing as the combinational generation, so existing coefficient generators are reused unchanged.

Parameters:
- NUM_A, 4, number of inputs
- WIDTH_A, 4, input width, unsigned
- NUM_H, 3, hidden neurons
- NUM_O, 3, output neurons, must be >= 2
- WIDTH_W, 8, signed weight width
- WIDTH_B0, 11, signed hidden bias width
- WIDTH_B1, 17, signed output bias width
- ACC0_W, 16, hidden accumulator width, signed
- ACC1_W, 28, output accumulator width, signed
- OUTWIDTH, $clog2(NUM_O), class index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- inp  in  NUM_A*WIDTH_A  input vector; input a at [a*WIDTH_A +: WIDTH_A]
- weights  in  (NUM_A*NUM_H+NUM_H*NUM_O)*WIDTH_W  layer-0 weight (h,a) at index h*NUM_A+a; layer-1 weight (o,h) at index NUM_A*NUM_H+o*NUM_H+h
- biases  in  NUM_H*WIDTH_B0+NUM_O*WIDTH_B1  B0[h] in the LSBs, then B1[o]
- in_valid  in  1  input vector valid
- in_ready  out  1  engine can accept an input vector
- out  out  OUTWIDTH  argmax class
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- busy  out  1  high in L0 and L1

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out=0, busy=0, and all accumulators, hidden registers and counters = 0.
- Reset mid-operation aborts the computation. The cycle after rst deasserts is IDLE with in_ready=1.
- FSM states: IDLE, L0, L1, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch inp, load acc0 with sign-extended B0[0], set h=0, a=0, go to L0.
- L0:
  - Each cycle: acc0 += zext(x[a]) * w0(h,a), with a++.
  - At a=NUM_A-1: hidden[h] <= max(acc0_next, 0) and acc0 <= B0[h+1]. After h=NUM_H-1, load acc1 with B1[0] and go to L1.
  - Duration: NUM_A*NUM_H cycles.
- L1:
  - Each cycle: acc1 += hidden[h] (unsigned, zero-extended) * w1(o,h).
  - At h=NUM_H-1, compare the final sum to best: update when o==0 or sum > best (strict). Ties therefore resolve to the lowest index. Then acc1 <= B1[o+1].
  - After o=NUM_O-1: out <= best index, out_valid <= 1, go to DONE.
  - Duration: NUM_H*NUM_O cycles.
- Latency: out_valid rises exactly NUM_A*NUM_H + NUM_H*NUM_O edges after the accepting edge (21 for the defaults).
- DONE:
  - out and out_valid are held stable until out_ready.
  - On out_valid&&out_ready, go to IDLE. out keeps its value, out_valid=0.
  - Minimum issue interval is latency + 2 cycles.
- in_ready=0 in L0, L1 and DONE. in_valid is ignored there; no queueing.
- Arithmetic:
  - Two's-complement throughout.
  - Product width is WIDTH_A+WIDTH_W+1, or ACC0_W+WIDTH_W+1 in layer 1, sign-extended into the accumulator.
  - Accumulator overflow wraps modulo 2^ACCn_W; there is no saturation.
  - hidden[h] is stored at ACC0_W bits and is non-negative after ReLU.
- weights, biases: read combinationally per cycle and must stay stable from acceptance until out_valid. inp is latched at acceptance.

Decomposition:
- Package mlp_seq_pkg:
  - state enum (IDLE, L0, L1, DONE)
  - product/accumulator width functions
  - weight and bias index functions (w0_idx, w1_idx, b0_lo, b1_lo)
- Sub-module mlp_mac: signed multiply-accumulate with a load-bias control and parametrised operand/accumulator widths, shared by both layers through operand muxes.

Test Plan:
- Zero weights, B1={5,9,-3}, any inp -> out=1, out_valid after exactly 21 cycles, busy high for 21 cycles.
- Zero weights, B1={7,7,7} -> out=0 (tie to lowest index).
- All L0 weights 1, B0={0,-100,-100}, inp all 15, w1(2,0)=2, other L1 weights 0, B1=0 -> hidden={60,0,0}, out=2.
- Same vector with B0 all -100 -> hidden all 0 (ReLU), result equals argmax of B1={-1,4,2} -> out=1.
- out_ready low for 10 cycles after out_valid, in_valid pulsed high meanwhile -> out and out_valid stable, in_ready=0, second vector not accepted; after the handshake, IDLE the next cycle.
- rst asserted at cycle 15 (mid-L1) -> next cycle out_valid=0, in_ready=1, busy=0; a fresh vector then gives the correct class at latency 21.
